spi_responder: RTL and testbench

- SPI slave (responder) for an FPGA-side register or data target, driven by an external SPI initiator such as the SAM or NINA host.
- It is the opposite end of the system's spi0..spi4 / nina_spi master ports: it receives MOSI words and returns MISO words.
- Internal side is a valid/ready word interface; SPI pins are oversampled with the system clock (clk_clk must be at least 4x SCLK).

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_responder.sv | 201 ++++++++++++++++++++
 tb/tb_spi_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM state encoding,
// the default idle word, and the SCLK edge-selection helper.
package spi_pkg;

  // Frame state: IDLE while deselected, ACTIVE while chip select is low.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Word returned when nothing is waiting in the TX holding register.
  localparam logic [7:0] TX_IDLE_DEFAULT = 8'hFF;

  // Returns the sample-edge strobe (want_sample=1) or the shift-edge strobe
  // (want_sample=0) for a given SPI mode. The sample edge is a rising SCLK
  // edge exactly when CPOL == CPHA (modes 0 and 3).
  function automatic logic pick_edge(input logic cpol,
                                     input logic cpha,
                                     input logic want_sample,
                                     input logic rise,
                                     input logic fall);
    logic sample_on_rise;
    sample_on_rise = (cpol == cpha);
    return (sample_on_rise == want_sample) ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a
// history register that produces single-cycle rise/fall strobes.
// A pin change becomes a strobe that the next clock edge acts on, giving
// three clk cycles from pin to internal event.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the pin and keep one cycle of history for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the values from before the clock edge; blocking here would collapse the
  // chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI responder (slave) with oversampled pins and valid/ready word ports.
// Receives MOSI words into rx_data/rx_valid and returns words from a
// one-deep TX holding register on MISO, MSB first. DATA_W must be >= 2.
module spi_responder
  import spi_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter logic              CPOL    = 1'b0,
  parameter logic              CPHA    = 1'b0,
  parameter logic [DATA_W-1:0] TX_IDLE = TX_IDLE_DEFAULT
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_CS,
  output logic              spi_MISO,
  output logic              spi_MISO_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Synchronised pin views
  logic w_sclk_rise, w_sclk_fall, w_sclk_unused_level;
  logic w_mosi, w_mosi_unused_rise, w_mosi_unused_fall;
  logic w_cs_rise, w_cs_fall, w_cs_unused_level;

  // Registered state
  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_load_pend;
  logic [DATA_W-1:0]   r_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_rx_overrun;
  logic                r_tx_underrun;
  logic                r_frame_abort;
  logic                r_miso_en;
  logic                r_busy;

  // Decoded events
  logic              w_sample, w_shift;
  logic              w_active_sample, w_active_shift;
  logic              w_load_here, w_load, w_shift_only;
  logic              w_word_done, w_tx_fire;
  logic [DATA_W-1:0] w_rx_next;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_pin   (spi_SCLK),
    .o_level (w_sclk_unused_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_pin   (spi_MOSI),
    .o_level (w_mosi),
    .o_rise  (w_mosi_unused_rise),
    .o_fall  (w_mosi_unused_fall)
  );

  // CS synchroniser resets to "selected" so a CS already low at reset
  // release produces no falling edge; a fresh high-then-low is required.
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_cs (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_pin   (spi_CS),
    .o_level (w_cs_unused_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_sample = pick_edge(CPOL, CPHA, 1'b1, w_sclk_rise, w_sclk_fall);
  assign w_shift  = pick_edge(CPOL, CPHA, 1'b0, w_sclk_rise, w_sclk_fall);

  // CS rising wins over any SCLK edge seen in the same cycle.
  assign w_active_sample = (r_state == ACTIVE) && !w_cs_rise && w_sample;
  assign w_active_shift  = (r_state == ACTIVE) && !w_cs_rise && w_shift;

  // Mode 0/2 loads after the last sample of a word; mode 1/3 loads on the
  // first shift edge of each word (bit counter still at zero).
  assign w_load_here  = CPHA ? (r_bit_cnt == '0) : r_load_pend;
  assign w_load       = ((r_state == IDLE) && w_cs_fall && !CPHA) ||
                        (w_active_shift && w_load_here);
  assign w_shift_only = w_active_shift && !w_load_here;

  assign w_word_done = (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};
  assign w_tx_fire   = tx_valid && !r_hold_full;

  // Frame FSM plus RX/TX datapath, all outputs registered.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_load_pend   <= 1'b0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;
      r_miso_en     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;

      // Holding register fills only when empty and is freed only when
      // full, so fill and load never collide.
      if (w_tx_fire) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end

      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift    <= TX_IDLE;
          r_tx_underrun <= 1'b1;
        end
      end else if (w_shift_only) begin
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
      end

      // A completing word below overrides this clear.
      if (rx_ready) r_rx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_bit_cnt   <= '0;
          r_load_pend <= 1'b0;
          if (w_cs_fall) begin
            r_state   <= ACTIVE;
            r_miso_en <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_miso_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            if (r_bit_cnt != '0) r_frame_abort <= 1'b1;
          end else begin
            if (w_active_sample) begin
              r_rx_shift <= w_rx_next;
              if (w_word_done) begin
                r_rx_data    <= w_rx_next;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= r_rx_valid && !rx_ready;
                r_bit_cnt    <= '0;
                r_load_pend  <= !CPHA;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
            if (w_load) r_load_pend <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_MISO    = r_miso_en & r_tx_shift[DATA_W-1];
  assign spi_MISO_en = r_miso_en;
  assign busy        = r_busy;
  assign tx_ready    = !r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
  assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 instance and a mode-3
// instance driven by a bit-banged initiator with SCLK at 1/16 of clk.
module tb_spi_responder;

  localparam int H = 8;  // clk cycles per SCLK half-period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mosi, rxr;
  logic [7:0] txd;

  // Mode 0 instance
  logic       sclk0, cs0, txv0;
  logic       miso0, en0, txr0, rxv0, ovr0, und0, abt0, busy0;
  logic [7:0] rxd0;

  // Mode 3 instance
  logic       sclk1, cs1, txv1;
  logic       miso1, en1, txr1, rxv1, ovr1, und1, abt1, busy1;
  logic [7:0] rxd1;

  spi_responder dut0 (
    .clk_clk(clk), .reset_reset(rst),
    .spi_SCLK(sclk0), .spi_MOSI(mosi), .spi_CS(cs0),
    .spi_MISO(miso0), .spi_MISO_en(en0),
    .tx_data(txd), .tx_valid(txv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rxr),
    .rx_overrun(ovr0), .tx_underrun(und0), .frame_abort(abt0), .busy(busy0)
  );

  spi_responder #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk_clk(clk), .reset_reset(rst),
    .spi_SCLK(sclk1), .spi_MOSI(mosi), .spi_CS(cs1),
    .spi_MISO(miso1), .spi_MISO_en(en1),
    .tx_data(txd), .tx_valid(txv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(rxr),
    .rx_overrun(ovr1), .tx_underrun(und1), .frame_abort(abt1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;

  // Pulse counters
  int n_und0 = 0, n_ovr0 = 0, n_abt0 = 0, n_und1 = 0, n_abt1 = 0;
  always @(posedge clk) begin
    if (und0) n_und0 <= n_und0 + 1;
    if (ovr0) n_ovr0 <= n_ovr0 + 1;
    if (abt0) n_abt0 <= n_abt0 + 1;
    if (und1) n_und1 <= n_und1 + 1;
    if (abt1) n_abt1 <= n_abt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 initiator: nbits MSB-first; optionally raises CS together with
  // the final SCLK trailing edge.
  task automatic m0_bits(input logic [7:0] mo, input int nbits, input bit end_frame,
                         output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(H);
      mi = {mi[6:0], miso0};
      sclk0 = 1'b1;
      wait_clk(H);
      sclk0 = 1'b0;
      if (end_frame && i == nbits - 1) cs0 = 1'b1;
    end
    wait_clk(H);
  endtask

  // Mode 3 initiator: one full word, CS left low.
  task automatic m3_word(input logic [7:0] mo, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < 8; i++) begin
      sclk1 = 1'b0;
      mosi  = mo[7-i];
      wait_clk(H);
      mi = {mi[6:0], miso1};
      sclk1 = 1'b1;
      wait_clk(H);
    end
  endtask

  task automatic push0(input logic [7:0] d);
    txd = d; txv0 = 1'b1; wait_clk(1); txv0 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d);
    txd = d; txv1 = 1'b1; wait_clk(1); txv1 = 1'b0;
  endtask

  task automatic rx_ack();
    rxr = 1'b1; wait_clk(1); rxr = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] got;
    int snap_u, snap_o, snap_a;

    rst = 1'b1; cs0 = 1'b1; cs1 = 1'b1; sclk0 = 1'b0; sclk1 = 1'b1;
    mosi = 1'b0; rxr = 1'b0; txd = '0; txv0 = 1'b0; txv1 = 1'b0;
    wait_clk(3);

    // Reset values
    check("rst_miso",     32'(miso0), 32'h0);
    check("rst_miso_en",  32'(en0),   32'h0);
    check("rst_rx_data",  32'(rxd0),  32'h0);
    check("rst_rx_valid", 32'(rxv0),  32'h0);
    check("rst_tx_ready", 32'(txr0),  32'h1);
    check("rst_busy",     32'(busy0), 32'h0);
    check("rst_pulses",   32'({ovr0, und0, abt0}), 32'h0);
    rst = 1'b0;
    wait_clk(5);

    // Test 1: mode 0, preloaded A5, receive 3C
    push0(8'hA5);
    check("t1_tx_ready_full", 32'(txr0), 32'h0);
    cs0 = 1'b0;
    wait_clk(H);
    check("t1_tx_ready_after_cs", 32'(txr0),  32'h1);
    check("t1_busy",              32'(busy0), 32'h1);
    check("t1_miso_en",           32'(en0),   32'h1);
    m0_bits(8'h3C, 8, 1'b1, got);
    check("t1_miso_word", 32'(got),  32'hA5);
    check("t1_rx_data",   32'(rxd0), 32'h3C);
    check("t1_rx_valid",  32'(rxv0), 32'h1);
    check("t1_busy_off",  32'(busy0), 32'h0);
    check("t1_en_off",    32'(en0),  32'h0);
    rx_ack();
    check("t1_rx_valid_clr", 32'(rxv0), 32'h0);

    // Test 2: empty holder, idle word returned, one underrun at CS fall
    snap_u = n_und0;
    cs0 = 1'b0;
    wait_clk(H);
    check("t2_underrun_at_cs", 32'(n_und0 - snap_u), 32'd1);
    m0_bits(8'h55, 8, 1'b1, got);
    check("t2_miso_word",      32'(got),  32'hFF);
    check("t2_rx_data",        32'(rxd0), 32'h55);
    check("t2_underrun_total", 32'(n_und0 - snap_u), 32'd1);
    rx_ack();

    // Test 3: two words in one frame, rx_ready low -> one overrun
    snap_o = n_ovr0;
    cs0 = 1'b0;
    wait_clk(H);
    m0_bits(8'h01, 8, 1'b0, got);
    m0_bits(8'h02, 8, 1'b1, got);
    check("t3_rx_data",  32'(rxd0), 32'h02);
    check("t3_rx_valid", 32'(rxv0), 32'h1);
    check("t3_overrun",  32'(n_ovr0 - snap_o), 32'd1);

    // Test 4: abort after 5 bits of F0, rx_valid/rx_data untouched
    snap_a = n_abt0;
    cs0 = 1'b0;
    wait_clk(H);
    m0_bits(8'hF0, 5, 1'b0, got);
    cs0 = 1'b1;
    wait_clk(H);
    check("t4_abort",    32'(n_abt0 - snap_a), 32'd1);
    check("t4_rx_valid", 32'(rxv0), 32'h1);
    check("t4_rx_data",  32'(rxd0), 32'h02);
    rx_ack();
    cs0 = 1'b0;
    wait_clk(H);
    m0_bits(8'h81, 8, 1'b1, got);
    check("t4_next_rx_data",  32'(rxd0), 32'h81);
    check("t4_next_rx_valid", 32'(rxv0), 32'h1);
    check("t4_next_miso",     32'(got),  32'hFF);
    check("t4_abort_once",    32'(n_abt0 - snap_a), 32'd1);

    // Test 5: mode 3 instance, tx C3, rx 7E
    check("t5_en_before", 32'(en1), 32'h0);
    push1(8'hC3);
    cs1 = 1'b0;
    wait_clk(H);
    check("t5_en_during", 32'(en1), 32'h1);
    m3_word(8'h7E, got);
    cs1 = 1'b1;
    wait_clk(H);
    check("t5_miso_word", 32'(got),  32'hC3);
    check("t5_rx_data",   32'(rxd1), 32'h7E);
    check("t5_rx_valid",  32'(rxv1), 32'h1);
    check("t5_en_after",  32'(en1),  32'h0);
    check("t5_no_underrun", 32'(n_und1), 32'd0);
    check("t5_no_abort",    32'(n_abt1), 32'd0);

    // Test 6: reset during bit 4 with CS low (rx_valid=1 from test 4)
    push0(8'h11);
    cs0 = 1'b0;
    wait_clk(H);
    push0(8'h22);
    check("t6_tx_ready_full", 32'(txr0), 32'h0);
    m0_bits(8'hB4, 4, 1'b0, got);
    mosi = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("t6_rst_rx_valid", 32'(rxv0),  32'h0);
    check("t6_rst_rx_data",  32'(rxd0),  32'h0);
    check("t6_rst_miso_en",  32'(en0),   32'h0);
    check("t6_rst_busy",     32'(busy0), 32'h0);
    check("t6_rst_tx_ready", 32'(txr0),  32'h1);
    check("t6_rst_miso",     32'(miso0), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(H);
    m0_bits(8'hC9, 8, 1'b0, got);
    check("t6_ignored_rx_valid", 32'(rxv0),  32'h0);
    check("t6_ignored_busy",     32'(busy0), 32'h0);
    cs0 = 1'b1;
    wait_clk(H);
    cs0 = 1'b0;
    wait_clk(H);
    m0_bits(8'h5A, 8, 1'b1, got);
    check("t6_fresh_rx_data",  32'(rxd0), 32'h5A);
    check("t6_fresh_rx_valid", 32'(rxv0), 32'h1);
    check("t6_fresh_miso",     32'(got),  32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
